// File: rtl/rx_uart_pkg.sv
// Shared types and constants for the extended UART receiver.
package rx_uart_pkg;

    // Receiver FSM states; WAIT is a generic bit-timer that returns to ret state.
    typedef enum logic [3:0] {
        IDLE,
        WAIT,
        VERIFY,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        PUSH,
        BRK_WAIT
    } rx_state_e;

    // Parity selector codes (2'b11 also means no parity).
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // FIFO entry layout: {brk, fe, pe, data[8:0]}.
    localparam int ENT_PE  = 9;
    localparam int ENT_FE  = 10;
    localparam int ENT_BRK = 11;
    localparam int ENTRY_W = 12;

    // Smallest usable baud divisor.
    localparam int DIV_MIN = 4;

    // 2-of-3 majority of the sampled line history.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/rx_uart_ex_fifo.sv
// Synchronous FIFO with combinational head read and an occupancy output.
module rx_uart_ex_fifo
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  do_wr;
    logic                  do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // Pointer update; a write and a read in the same cycle leave the level unchanged.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rx_uart_ex.sv
// UART receiver with runtime word length, parity and stop bits, majority-voted
// sampling, per-character error tagging and a sticky overrun flag.
//
// Read side handshake: rx_valid is high whenever data holds a character. Each
// cycle in which data_rd and rx_valid are both high consumes exactly one entry
// at the clock edge; data_rd while rx_valid is low has no effect.
module rx_uart_ex
    import rx_uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 16,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         rx_in,
    input  logic                         data_rd,
    input  logic                         status_clr,
    input  logic [DIV_WIDTH-1:0]         div,
    input  logic [3:0]                   cfg_data_bits,
    input  logic [1:0]                   cfg_parity,
    input  logic                         cfg_stop2,
    output logic [31:0]                  data,
    output logic                         rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overrun,
    output logic                         break_det,
    output rx_state_e                    dbg_state_o
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);

    // Line conditioning
    logic [2:0] sync_q;
    logic [2:0] hist_q;
    logic       vote;
    logic       start_edge;

    // Normalised configuration seen at the start edge
    logic [DIV_WIDTH-1:0] div_eff;
    logic [3:0]           bits_eff;
    logic [1:0]           par_eff;

    // FSM and frame registers
    rx_state_e                state_q;
    rx_state_e                ret_q;
    logic [DIV_WIDTH-1:0]     cnt_q;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [3:0]               bits_q;
    logic [1:0]               par_q;
    logic                     stop2_q;
    logic [3:0]               idx_q;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic                     pe_q;
    logic                     fe_q;
    logic                     par_bit_q;
    logic                     break_det_q;
    logic                     overrun_q;

    // FIFO interface
    logic                     push_w;
    logic                     brk_w;
    logic [ENTRY_W-1:0]       entry_d;
    logic [ENTRY_W-1:0]       fifo_rdata;
    logic                     fifo_empty;
    logic                     fifo_full;

    assign vote       = maj3(hist_q);
    // Start detection uses the raw synchronised edge so timing starts promptly.
    assign start_edge = hist_q[0] && !sync_q[2];

    assign div_eff  = (div < DIV_FLOOR) ? DIV_FLOOR : div;
    assign bits_eff = ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'd9)) ? cfg_data_bits : 4'd8;
    assign par_eff  = ((cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD)) ? cfg_parity : PAR_NONE;

    // A break is an all-zero character whose parity and stop samples were also low.
    assign brk_w  = (shift_q == '0) && ((par_q == PAR_NONE) || !par_bit_q) && fe_q;
    assign push_w = (state_q == PUSH);

    // Assemble the FIFO entry from the frame registers.
    always_comb begin
        entry_d                      = '0;
        entry_d[MAX_DATA_BITS-1:0]   = shift_q;
        entry_d[ENT_PE]              = pe_q;
        entry_d[ENT_FE]              = fe_q;
        entry_d[ENT_BRK]             = brk_w;
    end

    // Three-flop synchroniser followed by a three-sample vote history.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= 3'b111;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rx_in};
            hist_q <= {hist_q[1:0], sync_q[2]};
        end
    end

    // Receiver FSM. WAIT is loaded with N-1 so that the next decision state
    // runs N cycles after the one that started the timer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            cnt_q       <= '0;
            div_q       <= DIV_FLOOR;
            bits_q      <= 4'd8;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            idx_q       <= '0;
            shift_q     <= '0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            par_bit_q   <= 1'b0;
            break_det_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        div_q   <= div_eff;
                        bits_q  <= bits_eff;
                        par_q   <= par_eff;
                        stop2_q <= cfg_stop2;
                        cnt_q   <= (div_eff >> 1) - DIV_ONE;
                        ret_q   <= VERIFY;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q <= DIV_ONE) state_q <= ret_q;
                    else                  cnt_q   <= cnt_q - DIV_ONE;
                end
                VERIFY: begin
                    if (vote) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q     <= '0;
                        shift_q   <= '0;
                        pe_q      <= 1'b0;
                        fe_q      <= 1'b0;
                        par_bit_q <= 1'b0;
                        cnt_q     <= div_q - DIV_ONE;
                        ret_q     <= DATA;
                        state_q   <= WAIT;
                    end
                end
                DATA: begin
                    shift_q[idx_q] <= vote;
                    cnt_q          <= div_q - DIV_ONE;
                    state_q        <= WAIT;
                    if (idx_q == bits_q - 4'd1) begin
                        ret_q <= (par_q == PAR_NONE) ? STOP1 : PARITY;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        ret_q <= DATA;
                    end
                end
                PARITY: begin
                    par_bit_q <= vote;
                    pe_q      <= vote ^ ((par_q == PAR_EVEN) ? ^shift_q : ~^shift_q);
                    cnt_q     <= div_q - DIV_ONE;
                    ret_q     <= STOP1;
                    state_q   <= WAIT;
                end
                STOP1: begin
                    fe_q <= ~vote;
                    if (stop2_q) begin
                        cnt_q   <= div_q - DIV_ONE;
                        ret_q   <= STOP2;
                        state_q <= WAIT;
                    end else begin
                        state_q <= PUSH;
                    end
                end
                STOP2: begin
                    fe_q    <= fe_q | ~vote;
                    state_q <= PUSH;
                end
                PUSH: begin
                    if (brk_w) begin
                        break_det_q <= 1'b1;
                        state_q     <= BRK_WAIT;
                    end else begin
                        // Re-arm early so a following start bit is not missed.
                        cnt_q   <= (div_q >> 2) - DIV_ONE;
                        ret_q   <= IDLE;
                        state_q <= WAIT;
                    end
                end
                BRK_WAIT: begin
                    if (vote) begin
                        break_det_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a dropped push sets it and wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn)                   overrun_q <= 1'b0;
        else if (push_w && fifo_full)  overrun_q <= 1'b1;
        else if (status_clr)           overrun_q <= 1'b0;
    end

    rx_uart_ex_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en_i (push_w),
        .wdata_i (entry_d),
        .rd_en_i (data_rd),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign data        = fifo_empty ? 32'hFFFF_FFFF : {{(32-ENTRY_W){1'b0}}, fifo_rdata};
    assign rx_valid    = !fifo_empty;
    assign overrun     = overrun_q;
    assign break_det   = break_det_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rx_uart_ex.sv
// Self-checking bench for rx_uart_ex: directed frames plus randomised frames
// scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_rx_uart_ex;
  import rx_uart_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_in;
  logic        data_rd;
  logic        status_clr;
  logic [15:0] div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [31:0] data;
  logic        rx_valid;
  logic [4:0]  fifo_level;
  logic        overrun;
  logic        break_det;
  rx_state_e   dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_valid_at = -1;
  logic [11:0] exp_q[$];

  rx_uart_ex #(.MAX_DATA_BITS(9), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .rx_in(rx_in), .data_rd(data_rd),
    .status_clr(status_clr), .div(div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .data(data),
    .rx_valid(rx_valid), .fifo_level(fifo_level), .overrun(overrun),
    .break_det(break_det), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (frame level) ----------------
  function automatic int norm_bits(input logic [3:0] b);
    return (b >= 4'd5 && b <= 4'd9) ? int'(b) : 8;
  endfunction

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // Parity bit a correct transmitter sends: even -> total ones even.
  function automatic bit good_par(input logic [8:0] dm, input logic [1:0] p);
    int ones;
    ones = $countones(dm);
    return (p == 2'b01) ? bit'(ones % 2) : bit'(1 - (ones % 2));
  endfunction

  function automatic logic [11:0] model_entry(input logic [8:0] d, input logic [3:0] nb_cfg,
      input logic [1:0] par_cfg, input bit st2, input bit flip, input bit s1, input bit s2v);
    int nb;
    logic [8:0] dm;
    bit sent, pe, fe, brk;
    nb   = norm_bits(nb_cfg);
    dm   = d & 9'((1 << nb) - 1);
    sent = good_par(dm, par_cfg) ^ flip;
    pe   = par_on(par_cfg) && (sent != good_par(dm, par_cfg));
    fe   = !s1 || (st2 && !s2v);
    brk  = (dm == 9'd0) && (!par_on(par_cfg) || !sent) && fe;
    return {brk, fe, pe, dm};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rx_valid && first_valid_at < 0) first_valid_at = cyc;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop_one();
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] d, input int dv, input logic [3:0] nb_cfg,
      input logic [1:0] par_cfg, input bit st2, input bit flip, input bit s1, input bit s2v,
      input bit scramble);
    int nb;
    logic [8:0] dm;
    bit pb;
    nb = norm_bits(nb_cfg);
    dm = d & 9'((1 << nb) - 1);
    pb = good_par(dm, par_cfg) ^ flip;
    div = 16'(dv); cfg_data_bits = nb_cfg; cfg_parity = par_cfg; cfg_stop2 = st2;
    rx_in = 1'b0; ticks(dv);
    if (scramble) begin
      div = 16'($urandom_range(0, 40));
      cfg_data_bits = 4'($urandom_range(0, 15));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2 = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nb; i++) begin rx_in = dm[i]; ticks(dv); end
    if (par_on(par_cfg)) begin rx_in = pb; ticks(dv); end
    rx_in = s1; ticks(dv);
    if (st2) begin rx_in = s2v; ticks(dv); end
    rx_in = 1'b1;
    div = 16'(dv); cfg_data_bits = nb_cfg; cfg_parity = par_cfg; cfg_stop2 = st2;
    ticks(2 * dv);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; rx_in = 1'b1; data_rd = 1'b0; status_clr = 1'b0;
    div = 16'd16; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    ticks(3);
    resetn = 1'b1;
    ticks(2);
    n_checks++; if (data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data, 32'hFFFF_FFFF); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b expected 0", break_det); end
  endtask

  task automatic test_basic_8n1();
    int start_cyc;
    logic [11:0] e;
    exp_q.push_back(12'h0A5);
    first_valid_at = -1;
    start_cyc = cyc;
    send_frame(9'h0A5, 16, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (first_valid_at < 0 || (first_valid_at - start_cyc) < 144 || (first_valid_at - start_cyc) > 171) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles expected 144..171", first_valid_at - start_cyc);
    end
    e = exp_q.pop_front();
    n_checks++; if (data !== {20'h0, e}) begin n_fail++; $display("FAIL basic_data: got %h expected %h", data, {20'h0, e}); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    pop_one();
    n_checks++; if (data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL basic_after_pop: got %h expected %h", data, 32'hFFFF_FFFF); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after_pop: got %b expected 0", rx_valid); end
  endtask

  task automatic test_parity_7e2();
    logic [11:0] e;
    exp_q.push_back(12'h041);
    exp_q.push_back(12'h241);
    send_frame(9'h041, 16, 4'd7, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(9'h041, 16, 4'd7, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if (fifo_level !== 5'd2) begin n_fail++; $display("FAIL parity_level: got %0d expected 2", fifo_level); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (data !== {20'h0, e}) begin n_fail++; $display("FAIL parity_entry%0d: got %h expected %h", i, data, {20'h0, e}); end
      pop_one();
    end
  endtask

  task automatic test_stop2_framing();
    logic [11:0] e;
    exp_q.push_back(12'h5FF);
    send_frame(9'h1FF, 16, 4'd9, PAR_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (data !== {20'h0, e}) begin n_fail++; $display("FAIL stop2_fe: got %h expected %h", data, {20'h0, e}); end
    pop_one();
  endtask

  task automatic test_break();
    div = 16'd16; cfg_data_bits = 4'd8; cfg_parity = PAR_NONE; cfg_stop2 = 1'b0;
    rx_in = 1'b0;
    ticks(100);
    n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("FAIL break_early: got %b expected 0", break_det); end
    ticks(100);
    n_checks++; if (break_det !== 1'b1) begin n_fail++; $display("FAIL break_set: got %b expected 1", break_det); end
    ticks(30 * 16 - 200);
    n_checks++; if (break_det !== 1'b1) begin n_fail++; $display("FAIL break_hold: got %b expected 1", break_det); end
    n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL break_level_low: got %0d expected 1", fifo_level); end
    rx_in = 1'b1;
    ticks(16);
    n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("FAIL break_clear: got %b expected 0", break_det); end
    ticks(48);
    n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL break_level: got %0d expected 1", fifo_level); end
    n_checks++; if (data !== 32'h0000_0C00) begin n_fail++; $display("FAIL break_entry: got %h expected %h", data, 32'h0000_0C00); end
    pop_one();
  endtask

  task automatic test_glitch();
    int off;
    div = 16'd16; cfg_data_bits = 4'd8; cfg_parity = PAR_NONE; cfg_stop2 = 1'b0;
    rx_in = 1'b0; ticks(4); rx_in = 1'b1; ticks(64);
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL glitch_short_pulse: got level %0d expected 0", fifo_level); end
    // 0x00 with single-cycle high spikes near each sample point
    rx_in = 1'b0; ticks(6); rx_in = 1'b1; tick(); rx_in = 1'b0; ticks(9);
    for (int b = 0; b < 8; b++) begin
      off = 5 + (b % 4);
      rx_in = 1'b0; ticks(off); rx_in = 1'b1; tick(); rx_in = 1'b0; ticks(16 - off - 1);
    end
    rx_in = 1'b1; ticks(48);
    n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL glitch_level: got %0d expected 1", fifo_level); end
    n_checks++; if (data !== 32'h0000_0000) begin n_fail++; $display("FAIL glitch_vote: got %h expected %h", data, 32'h0); end
    pop_one();
  endtask

  task automatic test_overrun();
    logic [8:0] d;
    logic [11:0] e;
    for (int i = 0; i < 17; i++) begin
      d = 9'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back(model_entry(d, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1));
      send_frame(d, 16, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    n_checks++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL overrun_level: got %0d expected 16", fifo_level); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (data !== {20'h0, e}) begin n_fail++; $display("FAIL overrun_entry%0d: got %h expected %h", i, data, {20'h0, e}); end
      pop_one();
    end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    status_clr = 1'b1; tick(); status_clr = 1'b0; tick();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] e;
    send_frame(9'h055, 16, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rx_in = 1'b0; ticks(64);
    resetn = 1'b0; rx_in = 1'b1; ticks(2);
    resetn = 1'b1; tick();
    n_checks++; if (data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midreset_data: got %h expected %h", data, 32'hFFFF_FFFF); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", rx_valid); end
    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL midreset_level: got %0d expected 0", fifo_level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
    n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("FAIL midreset_break: got %b expected 0", break_det); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d expected %0d", dbg_state, IDLE); end
    exp_q.push_back(12'h03C);
    send_frame(9'h03C, 16, 4'd8, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if (data !== {20'h0, e}) begin n_fail++; $display("FAIL midreset_recover: got %h expected %h", data, {20'h0, e}); end
    pop_one();
  endtask

  task automatic test_random();
    logic [8:0] d;
    logic [3:0] nb;
    logic [1:0] par;
    bit st2, flip, s1, s2v;
    int dv;
    logic [11:0] e;
    for (int i = 0; i < 10; i++) begin
      d    = 9'($urandom_range(0, 511));
      nb   = 4'($urandom_range(0, 15));
      par  = 2'($urandom_range(0, 3));
      st2  = 1'($urandom_range(0, 1));
      flip = 1'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 3) != 0);
      s2v  = ($urandom_range(0, 3) != 0);
      dv   = $urandom_range(8, 24);
      exp_q.push_back(model_entry(d, nb, par, st2, flip, s1, s2v));
      send_frame(d, dv, nb, par, st2, flip, s1, s2v, 1'b1);
      ticks(3 * dv);
      e = exp_q.pop_front();
      n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL random_level%0d: got %0d expected 1", i, fifo_level); end
      n_checks++; if (data !== {20'h0, e}) begin n_fail++; $display("FAIL random_entry%0d: got %h expected %h (bits=%0d par=%0d stop2=%0d)", i, data, {20'h0, e}, nb, par, st2); end
      pop_one();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_8n1();
    test_parity_7e2();
    test_stop2_framing();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_uart_ex.md
Name: rx_uart_ex

Overview:
Parametrised successor UART receiver for the KianV SoC console/peripheral path.
- Adds runtime-selectable word length (5-9 bits), parity (none/even/odd) and 1 or 2 stop bits.
- Adds 3-sample majority voting, and per-character error tagging (parity, framing, break) stored in the FIFO alongside data.
- Adds a sticky overrun flag.
- Sits behind the UART MMIO register block; software reads characters plus their error bits through one 32-bit word.

Parameters:
- MAX_DATA_BITS, 9: width of the data field in the FIFO entry; must be 9.
- FIFO_DEPTH, 16: number of receive entries; must be a power of two, at least 2.
- DIV_WIDTH, 16: width of the baud divisor (clock cycles per bit).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- rx_in  in  1  asynchronous serial input, idle high
- data_rd  in  1  pop request; one entry popped per cycle while high and FIFO not empty
- status_clr  in  1  one-cycle pulse that clears the sticky overrun flag
- div  in  DIV_WIDTH  clocks per bit; values below 4 are treated as 4
- cfg_data_bits  in  4  word length, 5..9; values outside that range are treated as 8
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2  in  1  1 = two stop bits
- data  out  32  head FIFO entry; 32'hFFFF_FFFF when empty
- rx_valid  out  1  FIFO not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entry count
- overrun  out  1  sticky: a character was dropped because the FIFO was full
- break_det  out  1  high while a break condition is in progress (line held low past the frame)

Behaviour:
Input conditioning:
- rx_in goes through a 3-flop synchroniser; reset value 3'b111.
- A 3-bit history of the synchronised value feeds a majority vote (vote = at least 2 of 3 ones).
- All bit decisions use vote; the start-edge detection uses the raw synchronised 1→0 edge.

Configuration latch:
- div, cfg_data_bits, cfg_parity and cfg_stop2 are latched at start-edge detection.
- Changes mid-frame take effect from the next frame.

States (in rx_uart_pkg): IDLE, WAIT, VERIFY, DATA, PARITY, STOP1, STOP2, PUSH, BRK_WAIT.
- The WAIT counter is loaded with N and returns to return_state after N cycles (N ≥ 1).
- IDLE: on the start edge, load div>>1, return to VERIFY.
- VERIFY: vote=0 → load div, next DATA; vote=1 → IDLE (glitch rejected, nothing pushed).
- DATA: shift in LSB first into bit[idx]; after cfg_data_bits bits go to PARITY if parity is enabled, else STOP1. Load div between bits.
- PARITY: pe = vote XOR (even ? ^data : ~^data).
- STOP1: fe = ~vote. If cfg_stop2, load div and go to STOP2, else PUSH.
- STOP2: fe |= ~vote, then PUSH.
- Break: brk = all data bits 0, parity sample 0 (if parity enabled), and fe.

PUSH:
- Write entry {brk, fe, pe, data[8:0]}; bits above cfg_data_bits are zero.
- If the FIFO is full, drop the entry and set overrun, even if data_rd is asserted in the same cycle.
- Next state:
  - brk → BRK_WAIT with break_det=1.
  - Otherwise load div>>2 and return to IDLE (early re-arm).
- Errored characters are pushed, not discarded.

BRK_WAIT:
- Stay until vote=1, then clear break_det and go to IDLE.

Output data format:
- data[8:0] = character, data[9] = parity error, data[10] = framing error, data[11] = break, data[31:12] = 0.
- data is valid the cycle after the push.
- Simultaneous push and pop when not full: both occur; fifo_level is unchanged.

Overrun flag:
- Cleared by status_clr.
- If status_clr and a new overrun occur in the same cycle, set wins.

Reset:
- Resets all state, even mid-frame: state=IDLE, FIFO empty, overrun=0, break_det=0, rx_valid=0, fifo_level=0, data=32'hFFFF_FFFF.

Decomposition:
- Package rx_uart_pkg holds:
  - the state enum;
  - parity codes PAR_NONE/EVEN/ODD;
  - entry bit positions (ENT_PE=9, ENT_FE=10, ENT_BRK=11);
  - entry width ENTRY_W=12;
  - DIV_MIN=4.
- Sub-module: the existing fifo, instantiated with DATA_WIDTH=ENTRY_W, DEPTH=FIFO_DEPTH, and extended with a level output.

Test Plan:
- div=16, 8N1, send 0xA5 → data=32'h0000_00A5 with rx_valid=1 within 10*16+8 cycles of the start edge; data_rd → data=32'hFFFF_FFFF.
- 7E2 (cfg_data_bits=7, even parity, two stop bits), send 0x41 with correct parity then with parity inverted → data=32'h41 then 32'h241.
- 9-bit no parity, send 0x1FF with second stop bit low under cfg_stop2=1 → data=32'h5FF.
- Hold rx_in low for 30 bit times at 8N1 → single entry 32'h0000_0C00, break_det=1 until the line returns high, no further entries.
- Pulse rx_in low for 4 cycles at div=16 → no entry; a 1-cycle high glitch mid-bit is masked by the majority vote.
- Send 17 characters with no reads (FIFO_DEPTH=16) → fifo_level=16, overrun=1, the first 16 characters intact; status_clr → overrun=0; resetn low mid-frame → all outputs at reset values.
